// File: rtl/stream_demux_pkg.sv
// Purpose : shared types for the 1:2 stream demultiplexer and its per-output buffers.
// Contents: buffer occupancy state encoding.
// Users   : stream_buf2, stream_demux.
package stream_demux_pkg;

   // Occupancy of a 2-entry output buffer.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Purpose : bundles the input stream and both output streams of stream_demux.
// Modports: slave = the demux itself, master = the producer/consumers around it.
// Signals : in_* (producer side), a_*/b_* (consumer sides), valid/ready per stream.
interface stream_demux_if #(
   parameter int N = 4
) ();
   logic [N-1:0] in_data;
   logic         in_sel;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a_data;
   logic         a_valid;
   logic         a_ready;
   logic [N-1:0] b_data;
   logic         b_valid;
   logic         b_ready;

   modport slave (
      input  in_data, in_sel, in_valid, a_ready, b_ready,
      output in_ready, a_data, a_valid, b_data, b_valid
   );

   modport master (
      output in_data, in_sel, in_valid, a_ready, b_ready,
      input  in_ready, a_data, a_valid, b_data, b_valid
   );
endinterface

// File: rtl/stream_buf2.sv
// Purpose : 2-entry FIFO with registered head; push side sees only o_full, pop side valid/ready.
// Latency : a pushed beat reaches o_dat/o_vld one cycle later when it lands at the head.
// Backpr. : o_full is purely registered, so a same-cycle pop never frees a slot for a push.
// Ports   : clk, rst_n, i_push/i_push_dat/o_full (write), o_vld/i_pop_rdy/o_dat (read).
module stream_buf2
   import stream_demux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [N-1:0] i_push_dat,
   output logic         o_full,
   input  logic         i_pop_rdy,
   output logic         o_vld,
   output logic [N-1:0] o_dat
);

   buf_state_t   r_state;
   logic [N-1:0] r_head;
   logic [N-1:0] r_tail;
   logic         w_pop;

   assign w_pop  = (r_state != ST_EMPTY) & i_pop_rdy;
   assign o_vld  = (r_state != ST_EMPTY);
   assign o_full = (r_state == ST_FULL);
   assign o_dat  = r_head;

   // The caller never pushes while full, so FULL only reacts to pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (i_push) begin
                  r_head  <= i_push_dat;
                  r_state <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (i_push && w_pop) begin
                  // Head leaves and the new beat replaces it directly.
                  r_head <= i_push_dat;
               end else if (i_push) begin
                  r_tail  <= i_push_dat;
                  r_state <= ST_FULL;
               end else if (w_pop) begin
                  // Head register keeps its last value while empty.
                  r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  r_head  <= r_tail;
                  r_state <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Purpose : routes each input beat to output a (sel=0) or b (sel=1), one 2-deep buffer per output.
// Latency : one cycle from acceptance to the output when the beat is at the head of its buffer.
// Backpr. : in_ready follows the selected buffer's registered full flag only; a stalled output
//           never blocks beats to the other one.
// Ports   : clk, rst_n, bus (stream_demux_if.slave), a_count/b_count (accepted beats, wrapping).
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   stream_demux_if.slave    bus,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
);

   logic             w_full_a;
   logic             w_full_b;
   logic             w_acc;
   logic             w_push_a;
   logic             w_push_b;
   logic [CNT_W-1:0] r_a_count;
   logic [CNT_W-1:0] r_b_count;

   // No path from a_ready/b_ready here: only registered full flags gate the input.
   assign bus.in_ready = bus.in_sel ? ~w_full_b : ~w_full_a;
   assign w_acc        = bus.in_valid & bus.in_ready;
   assign w_push_a     = w_acc & ~bus.in_sel;
   assign w_push_b     = w_acc &  bus.in_sel;

   stream_buf2 #(.N(N)) u_buf_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push_a),
      .i_push_dat (bus.in_data),
      .o_full     (w_full_a),
      .i_pop_rdy  (bus.a_ready),
      .o_vld      (bus.a_valid),
      .o_dat      (bus.a_data)
   );

   stream_buf2 #(.N(N)) u_buf_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push_b),
      .i_push_dat (bus.in_data),
      .o_full     (w_full_b),
      .i_pop_rdy  (bus.b_ready),
      .o_vld      (bus.b_valid),
      .o_dat      (bus.b_data)
   );

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (w_push_a) r_a_count <= r_a_count + CNT_W'(1);
         if (w_push_b) r_b_count <= r_b_count + CNT_W'(1);
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_count;
   logic [7:0] b_count;
   logic [1:0] w_a_count;
   logic [1:0] w_b_count;

   stream_demux_if #(.N(4)) bus ();
   stream_demux_if #(.N(4)) ifw ();

   // Second instance with narrow counters sees the identical stream.
   assign ifw.in_data  = bus.in_data;
   assign ifw.in_sel   = bus.in_sel;
   assign ifw.in_valid = bus.in_valid;
   assign ifw.a_ready  = bus.a_ready;
   assign ifw.b_ready  = bus.b_ready;

   stream_demux #(.N(4), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .a_count (a_count),
      .b_count (b_count)
   );

   stream_demux #(.N(4), .CNT_W(2)) dut_w (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (ifw),
      .a_count (w_a_count),
      .b_count (w_b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   // Reference model: one queue per output, counts as plain integers.
   logic [3:0] qa[$];
   logic [3:0] qb[$];
   logic [3:0] last_a, last_b;
   int         cnt_a, cnt_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      last_a = 4'h0;
      last_b = 4'h0;
      cnt_a  = 0;
      cnt_b  = 0;
   endtask

   task automatic check_outputs(input logic s);
      logic exp_rdy;
      exp_rdy = s ? (qb.size() < 2) : (qa.size() < 2);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("a_valid", {31'd0, bus.a_valid}, {31'd0, qa.size() > 0});
      chk("a_data", {28'd0, bus.a_data}, {28'd0, last_a});
      chk("b_valid", {31'd0, bus.b_valid}, {31'd0, qb.size() > 0});
      chk("b_data", {28'd0, bus.b_data}, {28'd0, last_b});
      chk("a_count", {24'd0, a_count}, cnt_a % 256);
      chk("b_count", {24'd0, b_count}, cnt_b % 256);
      chk("wrap_a_count", {30'd0, w_a_count}, cnt_a % 4);
      chk("wrap_b_count", {30'd0, w_b_count}, cnt_b % 4);
   endtask

   // One cycle: drive at negedge, check just after, advance model on posedge.
   task automatic step(input logic v, input logic s, input logic [3:0] d,
                       input logic ra, input logic rb, output logic acc);
      logic exp_rdy;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = ra;
      bus.b_ready  = rb;
      #1;
      check_outputs(s);
      exp_rdy = s ? (qb.size() < 2) : (qa.size() < 2);
      acc = v & exp_rdy;
      @(posedge clk);
      if (qa.size() > 0 && ra) void'(qa.pop_front());
      if (qb.size() > 0 && rb) void'(qb.pop_front());
      if (acc) begin
         if (s) begin qb.push_back(d); cnt_b++; end
         else   begin qa.push_back(d); cnt_a++; end
      end
      if (qa.size() > 0) last_a = qa[0];
      if (qb.size() > 0) last_b = qb[0];
   endtask

   // Hold a beat until accepted, bounded.
   task automatic send(input logic s, input logic [3:0] d, input logic ra, input logic rb);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         step(1'b1, s, d, ra, rb, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic       acc;
   logic [3:0] wrap_seq [5];

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = 4'h0;
      bus.a_ready  = 1'b1;
      bus.b_ready  = 1'b1;
      model_clear();
      #2;
      // Reset state while rst_n is low.
      chk("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
      chk("rst_a_data", {28'd0, bus.a_data}, 32'd0);
      chk("rst_counts", {16'd0, a_count, b_count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1. Idle after reset.
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
      step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, acc);

      // 2. Interleaved stream, both consumers ready.
      send(1'b0, 4'h1, 1'b1, 1'b1);
      send(1'b1, 4'h2, 1'b1, 1'b1);
      send(1'b0, 4'h3, 1'b1, 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
      chk("t2_a_count", {24'd0, a_count}, 32'd2);
      chk("t2_b_count", {24'd0, b_count}, 32'd1);

      // 3. Back-pressure on a: third beat refused, head held, order preserved.
      do_reset();
      send(1'b0, 4'h5, 1'b0, 1'b1);
      send(1'b0, 4'h6, 1'b0, 1'b1);
      step(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, acc);
      chk("t3_refused", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_head_held", {28'd0, bus.a_data}, 32'h5);
      send(1'b0, 4'h7, 1'b1, 1'b1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);

      // 4. Isolation: a full and stalled, b keeps flowing.
      send(1'b0, 4'hC, 1'b0, 1'b1);
      send(1'b0, 4'hD, 1'b0, 1'b1);
      send(1'b1, 4'h9, 1'b0, 1'b1);
      send(1'b1, 4'hA, 1'b0, 1'b1);
      step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, acc);
      chk("t4_a_head", {28'd0, bus.a_data}, 32'hC);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);

      // 5. Counter wrap on the 2-bit instance.
      do_reset();
      wrap_seq[0] = 4'd1; wrap_seq[1] = 4'd2; wrap_seq[2] = 4'd3;
      wrap_seq[3] = 4'd0; wrap_seq[4] = 4'd1;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 4'(i), 1'b1, 1'b1, acc);
         #1;
         chk("t5_wrap_seq", {30'd0, w_b_count}, {28'd0, wrap_seq[i]});
      end
      step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, acc);

      // 6. Asynchronous reset with both buffers full.
      send(1'b0, 4'h1, 1'b0, 1'b0);
      send(1'b0, 4'h2, 1'b0, 1'b0);
      send(1'b1, 4'h3, 1'b0, 1'b0);
      send(1'b1, 4'h4, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_a_valid", {31'd0, bus.a_valid}, 32'd0);
      chk("t6_b_valid", {31'd0, bus.b_valid}, 32'd0);
      chk("t6_counts", {16'd0, a_count, b_count}, 32'd0);
      chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      send(1'b1, 4'hE, 1'b1, 1'b1);
      step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, acc);
      chk("t6_new_beat", {28'd0, bus.b_data}, 32'hE);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, acc);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
